// File: rtl/frame_buffer_scheduler.sv
// Double-buffer controller: starts the renderer on vsync, steers renderer writes to the
// back bank, serves display reads from the front bank and swaps banks on completed frames.
module frame_buffer_scheduler #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              VS,
   output logic              RENDER_START,
   input  logic              RENDER_DONE,
   input  logic              WR_EN,
   input  logic [8:0]        WR_X,
   input  logic [8:0]        WR_Y,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              RD_REQ,
   input  logic [ADDR_W-1:0] RD_ADDR,
   output logic [DATA_W-1:0] RD_DATA,
   output logic              RD_VALID,
   output logic [ADDR_W-1:0] BANK0_ADDR,
   output logic              BANK0_WE,
   output logic [DATA_W-1:0] BANK0_WDATA,
   input  logic [DATA_W-1:0] BANK0_RDATA,
   output logic [ADDR_W-1:0] BANK1_ADDR,
   output logic              BANK1_WE,
   output logic [DATA_W-1:0] BANK1_WDATA,
   input  logic [DATA_W-1:0] BANK1_RDATA,
   output logic              FRONT_SEL,
   output logic              OVERRUN,
   output logic [CNT_W-1:0]  DROP_CNT
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RENDERING = 2'd1,
      READY     = 2'd2
   } state_t;

   state_t              state_r, state_nx_s;
   logic                vs_meta_r, vs_sync_r, vs_prev_r;
   logic                vs_fall_s;
   logic                start_s, overrun_s, swap_s;
   logic                rd_sel_r;
   logic                wr_accept_s;
   logic [ADDR_W-1:0]   wr_addr_s;
   logic [DATA_W-1:0]   wr_data_s;

   // VS synchronizer and previous-value flop; idle level is high
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vs_meta_r <= 1'b1;
         vs_sync_r <= 1'b1;
         vs_prev_r <= 1'b1;
      end else begin
         vs_meta_r <= VS;
         vs_sync_r <= vs_meta_r;
         vs_prev_r <= vs_sync_r;
      end
   end

   assign vs_fall_s = vs_prev_r & ~vs_sync_r;

   // Frame FSM next-state and event decode
   always_comb begin
      state_nx_s = state_r;
      start_s    = 1'b0;
      overrun_s  = 1'b0;
      swap_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (vs_fall_s) begin
               state_nx_s = RENDERING;
               start_s    = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RENDERING: begin
            // done coinciding with vsync counts as a completed frame: swap and restart
            if (RENDER_DONE && vs_fall_s) begin
               swap_s  = 1'b1;
               start_s = 1'b1;
            end else if (RENDER_DONE) begin
               state_nx_s = READY;
            end else if (vs_fall_s) begin
               overrun_s = 1'b1;
            end else begin
               state_nx_s = RENDERING;
            end
         end
         READY: begin
            if (vs_fall_s) begin
               state_nx_s = RENDERING;
               swap_s     = 1'b1;
               start_s    = 1'b1;
            end else begin
               state_nx_s = READY;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM state, pulses, bank selection and drop counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r      <= IDLE;
         RENDER_START <= 1'b0;
         OVERRUN      <= 1'b0;
         FRONT_SEL    <= 1'b0;
         DROP_CNT     <= {CNT_W{1'b0}};
      end else begin
         state_r      <= state_nx_s;
         RENDER_START <= start_s;
         OVERRUN      <= overrun_s;
         if (swap_s) FRONT_SEL <= ~FRONT_SEL;
         if (overrun_s && (DROP_CNT != {CNT_W{1'b1}})) DROP_CNT <= DROP_CNT + CNT_W'(1);
      end
   end

   // Read request and the bank it targeted travel together so data stays coherent across a swap
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RD_VALID <= 1'b0;
         rd_sel_r <= 1'b0;
      end else begin
         RD_VALID <= RD_REQ;
         rd_sel_r <= FRONT_SEL;
      end
   end

   // Read data mux, held at zero when no read is returning
   always_comb begin
      RD_DATA = {DATA_W{1'b0}};
      if (RD_VALID) begin
         RD_DATA = rd_sel_r ? BANK1_RDATA : BANK0_RDATA;
      end else begin
         RD_DATA = {DATA_W{1'b0}};
      end
   end

   // Write qualification and bank port steering; the front bank is never written
   always_comb begin
      wr_accept_s = WR_EN && (state_r == RENDERING) && !WR_X[8] && !WR_Y[8];
      wr_addr_s   = {ADDR_W{1'b0}};
      wr_data_s   = {DATA_W{1'b0}};
      BANK0_ADDR  = {ADDR_W{1'b0}};
      BANK0_WE    = 1'b0;
      BANK0_WDATA = {DATA_W{1'b0}};
      BANK1_ADDR  = {ADDR_W{1'b0}};
      BANK1_WE    = 1'b0;
      BANK1_WDATA = {DATA_W{1'b0}};
      if (wr_accept_s) begin
         wr_addr_s = ADDR_W'({WR_Y[7:0], WR_X[7:0]});
         wr_data_s = WR_DATA;
      end else begin
         wr_addr_s = {ADDR_W{1'b0}};
         wr_data_s = {DATA_W{1'b0}};
      end
      if (FRONT_SEL) begin
         BANK1_ADDR  = RD_ADDR;
         BANK0_ADDR  = wr_addr_s;
         BANK0_WE    = wr_accept_s;
         BANK0_WDATA = wr_data_s;
      end else begin
         BANK0_ADDR  = RD_ADDR;
         BANK1_ADDR  = wr_addr_s;
         BANK1_WE    = wr_accept_s;
         BANK1_WDATA = wr_data_s;
      end
   end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with behavioural bank memories and a read scoreboard.
module tb_frame_buffer_scheduler;

   logic        CLK, RESET, VS, RENDER_START, RENDER_DONE, WR_EN;
   logic [8:0]  WR_X, WR_Y;
   logic [3:0]  WR_DATA, RD_DATA, BANK0_WDATA, BANK1_WDATA, BANK0_RDATA, BANK1_RDATA;
   logic        RD_REQ, RD_VALID, BANK0_WE, BANK1_WE, FRONT_SEL, OVERRUN;
   logic [15:0] RD_ADDR, BANK0_ADDR, BANK1_ADDR;
   logic [7:0]  DROP_CNT;

   logic [3:0]  mem0 [0:65535];
   logic [3:0]  mem1 [0:65535];
   logic [3:0]  exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          start_cnt = 0;
   int          ovr_cnt = 0;
   int          s0, o0, lat;

   frame_buffer_scheduler #(.ADDR_W(16), .DATA_W(4), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .VS(VS), .RENDER_START(RENDER_START), .RENDER_DONE(RENDER_DONE),
      .WR_EN(WR_EN), .WR_X(WR_X), .WR_Y(WR_Y), .WR_DATA(WR_DATA),
      .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
      .BANK0_ADDR(BANK0_ADDR), .BANK1_ADDR(BANK1_ADDR), .BANK0_WE(BANK0_WE), .BANK1_WE(BANK1_WE),
      .BANK0_WDATA(BANK0_WDATA), .BANK1_WDATA(BANK1_WDATA),
      .BANK0_RDATA(BANK0_RDATA), .BANK1_RDATA(BANK1_RDATA),
      .FRONT_SEL(FRONT_SEL), .OVERRUN(OVERRUN), .DROP_CNT(DROP_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Bank models with one-cycle registered read
   always @(posedge CLK) begin
      if (BANK0_WE) mem0[BANK0_ADDR] <= BANK0_WDATA;
      if (BANK1_WE) mem1[BANK1_ADDR] <= BANK1_WDATA;
      BANK0_RDATA <= mem0[BANK0_ADDR];
      BANK1_RDATA <= mem1[BANK1_ADDR];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse counters and read-data scoreboard, sampled mid-cycle
   always @(negedge CLK) begin
      if (RENDER_START) start_cnt++;
      if (OVERRUN) ovr_cnt++;
      if (RD_VALID) begin
         if (exp_q.size() == 0) chk("rd_unexpected", {31'd0, RD_VALID}, 32'd0);
         else chk("rd_data", {28'd0, RD_DATA}, {28'd0, exp_q.pop_front()});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic vs_pulse();
      VS = 1'b0;
      tick(6);
      VS = 1'b1;
      tick(3);
   endtask

   task automatic wr(input logic [8:0] x, input logic [8:0] y, input logic [3:0] d);
      WR_EN = 1'b1; WR_X = x; WR_Y = y; WR_DATA = d;
      #1;
   endtask

   initial begin
      RESET = 1'b1; VS = 1'b1; RENDER_DONE = 1'b0; WR_EN = 1'b0; WR_X = 9'd0; WR_Y = 9'd0;
      WR_DATA = 4'd0; RD_REQ = 1'b0; RD_ADDR = 16'd0;
      tick(3);
      chk("rst_start", {31'd0, RENDER_START}, 32'd0);
      chk("rst_overrun", {31'd0, OVERRUN}, 32'd0);
      chk("rst_rd_valid", {31'd0, RD_VALID}, 32'd0);
      chk("rst_rd_data", {28'd0, RD_DATA}, 32'd0);
      chk("rst_front", {31'd0, FRONT_SEL}, 32'd0);
      chk("rst_drop", {24'd0, DROP_CNT}, 32'd0);
      chk("rst_we", {30'd0, BANK0_WE, BANK1_WE}, 32'd0);
      RESET = 1'b0;
      tick(2);

      wr(9'd5, 9'd3, 4'hA);
      chk("idle_wr_drop", {31'd0, BANK1_WE}, 32'd0);
      chk("idle_wr_addr", {16'd0, BANK1_ADDR}, 32'd0);
      WR_EN = 1'b0;
      tick(1);

      // VS fall to RENDER_START: two synchronizer flops plus the FSM register
      s0 = start_cnt;
      VS = 1'b0;
      lat = 0;
      while (!RENDER_START && lat < 8) begin
         tick(1);
         lat++;
      end
      chk("start_latency", lat, 32'd3);
      tick(3);
      VS = 1'b1;
      tick(3);
      chk("start_once", start_cnt - s0, 32'd1);
      chk("front_first", {31'd0, FRONT_SEL}, 32'd0);

      wr(9'd5, 9'd3, 4'hA);
      chk("wr_b1_we", {31'd0, BANK1_WE}, 32'd1);
      chk("wr_b1_addr", {16'd0, BANK1_ADDR}, 32'h0305);
      chk("wr_b1_data", {28'd0, BANK1_WDATA}, 32'hA);
      chk("wr_b0_we", {31'd0, BANK0_WE}, 32'd0);
      tick(1);
      wr(9'd255, 9'd255, 4'h3);
      chk("edge_b1_we", {31'd0, BANK1_WE}, 32'd1);
      chk("edge_b1_addr", {16'd0, BANK1_ADDR}, 32'hFFFF);
      tick(1);
      wr(9'd5, 9'd256, 4'h5);
      chk("y256_we", {30'd0, BANK0_WE, BANK1_WE}, 32'd0);
      tick(1);
      wr(9'd256, 9'd0, 4'h5);
      chk("x256_we", {30'd0, BANK0_WE, BANK1_WE}, 32'd0);
      WR_EN = 1'b0;
      tick(1);

      RENDER_DONE = 1'b1;
      tick(1);
      RENDER_DONE = 1'b0;
      wr(9'd1, 9'd1, 4'h6);
      chk("ready_wr_drop", {30'd0, BANK0_WE, BANK1_WE}, 32'd0);
      WR_EN = 1'b0;
      tick(1);
      s0 = start_cnt;
      vs_pulse();
      chk("swap_front", {31'd0, FRONT_SEL}, 32'd1);
      chk("swap_start", start_cnt - s0, 32'd1);

      RD_REQ = 1'b1; RD_ADDR = 16'h0305; exp_q.push_back(4'hA);
      tick(1);
      RD_ADDR = 16'hFFFF; exp_q.push_back(4'h3);
      tick(1);
      RD_REQ = 1'b0;
      tick(2);
      chk("rd_drained1", exp_q.size(), 32'd0);

      wr(9'd5, 9'd3, 4'h7);
      chk("wr_b0_we", {31'd0, BANK0_WE}, 32'd1);
      chk("wr_b0_addr", {16'd0, BANK0_ADDR}, 32'h0305);
      chk("wr_b1_idle", {31'd0, BANK1_WE}, 32'd0);
      chk("front_rd_addr", {16'd0, BANK1_ADDR}, 32'hFFFF);
      WR_EN = 1'b0;
      tick(1);

      s0 = start_cnt; o0 = ovr_cnt;
      vs_pulse();
      chk("ovr_pulse", ovr_cnt - o0, 32'd1);
      chk("ovr_drop1", {24'd0, DROP_CNT}, 32'd1);
      chk("ovr_front", {31'd0, FRONT_SEL}, 32'd1);
      chk("ovr_no_start", start_cnt - s0, 32'd0);
      repeat (299) vs_pulse();
      chk("drop_sat", {24'd0, DROP_CNT}, 32'hFF);
      chk("ovr_total", ovr_cnt - o0, 32'd300);

      // RENDER_DONE in the vs_fall cycle, with a read and a write issued in that same cycle
      s0 = start_cnt; o0 = ovr_cnt;
      VS = 1'b0;
      tick(2);
      RENDER_DONE = 1'b1;
      RD_REQ = 1'b1; RD_ADDR = 16'h0305; exp_q.push_back(4'hA);
      wr(9'd5, 9'd3, 4'h9);
      chk("swapcyc_b0_we", {31'd0, BANK0_WE}, 32'd1);
      tick(1);
      RENDER_DONE = 1'b0; RD_REQ = 1'b0; WR_EN = 1'b0;
      chk("same_start", {31'd0, RENDER_START}, 32'd1);
      chk("same_front", {31'd0, FRONT_SEL}, 32'd0);
      tick(6);
      VS = 1'b1;
      tick(3);
      chk("same_start_once", start_cnt - s0, 32'd1);
      chk("same_no_ovr", ovr_cnt - o0, 32'd0);
      chk("same_drop", {24'd0, DROP_CNT}, 32'hFF);
      RD_REQ = 1'b1; RD_ADDR = 16'h0305; exp_q.push_back(4'h9);
      tick(1);
      RD_REQ = 1'b0;
      tick(2);
      chk("rd_drained2", exp_q.size(), 32'd0);

      RENDER_DONE = 1'b1;
      tick(1);
      RENDER_DONE = 1'b0;
      vs_pulse();
      chk("pre_rst_front", {31'd0, FRONT_SEL}, 32'd1);
      RESET = 1'b1;
      #1;
      chk("mid_rst_front", {31'd0, FRONT_SEL}, 32'd0);
      chk("mid_rst_drop", {24'd0, DROP_CNT}, 32'd0);
      chk("mid_rst_pulses", {29'd0, RENDER_START, OVERRUN, RD_VALID}, 32'd0);
      tick(2);
      RESET = 1'b0;
      tick(2);
      s0 = start_cnt;
      vs_pulse();
      chk("post_rst_start", start_cnt - s0, 32'd1);
      wr(9'd7, 9'd2, 4'h1);
      chk("post_rst_b1_we", {31'd0, BANK1_WE}, 32'd1);
      chk("post_rst_b1_addr", {16'd0, BANK1_ADDR}, 32'h0207);
      chk("post_rst_b0_we", {31'd0, BANK0_WE}, 32'd0);
      WR_EN = 1'b0;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Double-buffer controller between the layer renderer, the display scan-out and two 256x256x4 pixel banks.
- Each frame it starts the renderer on the vsync falling edge and steers renderer writes into the back bank.
- It serves display reads from the front bank and swaps front and back on vsync once a frame is complete.
- It detects render overruns and counts dropped frames.

Parameters:
- ADDR_W, 16, bank address width; address = {y[7:0], x[7:0]}.
- DATA_W, 4, pixel (palette index) width.
- CNT_W, 8, dropped-frame counter width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- VS  in  1  display vsync, active low, asynchronous to CLK logic.
- RENDER_START  out  1  one-cycle pulse; renderer begins a frame.
- RENDER_DONE  in  1  one-cycle pulse; renderer finished all layers.
- WR_EN  in  1  renderer pixel write strobe.
- WR_X  in  9  renderer column.
- WR_Y  in  9  renderer row.
- WR_DATA  in  DATA_W  renderer pixel.
- RD_REQ  in  1  display read request.
- RD_ADDR  in  ADDR_W  display read address.
- RD_DATA  out  DATA_W  front-bank pixel.
- RD_VALID  out  1  RD_DATA valid.
- BANK0_ADDR / BANK1_ADDR  out  ADDR_W  bank addresses.
- BANK0_WE / BANK1_WE  out  1  bank write enables.
- BANK0_WDATA / BANK1_WDATA  out  DATA_W  bank write data.
- BANK0_RDATA / BANK1_RDATA  in  DATA_W  bank read data, 1-cycle registered latency.
- FRONT_SEL  out  1  bank currently displayed (0 = BANK0).
- OVERRUN  out  1  one-cycle pulse when a frame is dropped.
- DROP_CNT  out  CNT_W  saturating count of dropped frames.

Behaviour:
- Reset values (async, RESET high):
  - FSM = IDLE, FRONT_SEL = 0, DROP_CNT = 0.
  - RENDER_START, OVERRUN, RD_VALID, all WE = 0; RD_DATA = 0.
  - Synchronizer flops = 1 (VS idle high).
- VS sync and edge detect:
  - VS passes through a 2-flop synchronizer and a registered previous-value flop.
  - vs_fall = prev & ~sync, asserted for exactly 1 cycle per low pulse.
  - Latency from the VS pin to vs_fall is 2-3 cycles.
- FSM states: IDLE, RENDERING, READY.
  - IDLE: on vs_fall, pulse RENDER_START next cycle and go to RENDERING. FRONT_SEL unchanged.
  - RENDERING: on RENDER_DONE, go to READY. On vs_fall without RENDER_DONE: no swap, pulse OVERRUN, DROP_CNT += 1 (saturating at all-ones), stay in RENDERING.
  - RENDERING, RENDER_DONE and vs_fall in the same cycle: treated as done then swap. Toggle FRONT_SEL, pulse RENDER_START, stay in RENDERING, no OVERRUN.
  - READY: on vs_fall, toggle FRONT_SEL, pulse RENDER_START, go to RENDERING.
- Write path (back bank = ~FRONT_SEL):
  - A write is accepted only when WR_EN=1, state is RENDERING, WR_X < 256 and WR_Y < 256.
  - On accept: back-bank ADDR = {WR_Y[7:0], WR_X[7:0]}, WDATA = WR_DATA, WE = 1, all combinational in the same cycle.
  - Otherwise back-bank WE = 0, ADDR = 0, WDATA = 0.
  - Writes in IDLE or READY, and out-of-range writes (e.g. Y=256), are dropped silently.
  - The front bank is never written.
- Read path:
  - Front-bank ADDR = RD_ADDR, combinational.
  - RD_REQ and FRONT_SEL are registered together. RD_VALID = RD_REQ delayed 1 cycle.
  - RD_DATA = registered-sel ? BANK1_RDATA : BANK0_RDATA. Data is coherent even if a swap occurs between request and data.
- Swap timing:
  - FRONT_SEL toggles on the cycle after vs_fall.
  - A back-bank write issued in that same vs_fall cycle is still directed to the pre-toggle back bank.
- Reset mid-frame returns to IDLE. The partially rendered back bank is abandoned, and the next vs_fall starts a fresh frame into bank 1.

Test Plan:
- Reset, then VS high→low → RENDER_START pulses exactly once, 3-4 cycles after the VS edge; FRONT_SEL stays 0; state RENDERING.
- In RENDERING, write X=5, Y=3, data 4'hA → BANK1_ADDR=16'h0305, BANK1_WE=1, BANK0_WE=0 that cycle. Write with Y=256 → no WE.
- RENDER_DONE, then VS fall → FRONT_SEL=1, new RENDER_START. RD_REQ at addr 16'h0305 → RD_VALID one cycle later with RD_DATA=4'hA.
- Two VS falls with no RENDER_DONE → FRONT_SEL unchanged, OVERRUN pulses, DROP_CNT=1. Force 300 overruns → DROP_CNT saturates at 8'hFF.
- RENDER_DONE and vs_fall in the same cycle → swap, single RENDER_START, no OVERRUN. RD_REQ issued on the swap cycle returns old-front-bank data.
- Assert RESET mid-RENDERING → all outputs at reset values immediately; next VS fall restarts with writes to BANK1.
